// File: rtl/gpio_regbank.sv
// GPIO and chip-ID register bank: req/ack bus handshake, 2-flop input synchroniser,
// and optional per-pin edge interrupts (enabled by defining GPIO_REGBANK_IRQ_EN).
module gpio_regbank #(
  parameter int          GPIO_W   = 16,
  parameter logic [31:0] CNAME    = 32'h0,
  parameter logic [31:0] CVERSION = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              r_wn,
  input  logic [4:0]        addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic              err,
  output logic [31:0]       rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state_q, state_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [GPIO_W-1:0] oe_q, oe_d;
  logic [GPIO_W-1:0] out_q, out_d;
  logic [31:0]       scratch_q, scratch_d;
  logic [GPIO_W-1:0] sync1_q, sync1_d;
  logic [GPIO_W-1:0] sync2_q, sync2_d;
  logic [31:0]       rd_val;
  logic              bad;
`ifdef GPIO_REGBANK_IRQ_EN
  logic [GPIO_W-1:0] prev_q, prev_d;
  logic [GPIO_W-1:0] mask_q, mask_d;
  logic [GPIO_W-1:0] status_q, status_d;
  logic [GPIO_W-1:0] edge_q, edge_d;
  logic              irq_q, irq_d;
  logic [GPIO_W-1:0] w1c;
  logic [GPIO_W-1:0] det;
`endif

  always_comb begin
    state_d   = IDLE;
    ack_d     = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    oe_d      = oe_q;
    out_d     = out_q;
    scratch_d = scratch_q;
    sync1_d   = gpio_in;
    sync2_d   = sync1_q;
    rd_val    = '0;
    bad       = 1'b0;
`ifdef GPIO_REGBANK_IRQ_EN
    prev_d    = sync2_q;
    mask_d    = mask_q;
    edge_d    = edge_q;
    w1c       = '0;
`endif

    // Requests are only accepted in IDLE; the access completes at the accepting edge.
    if (state_q == IDLE && req) begin
      state_d = RESP;
      ack_d   = 1'b1;
      case (addr)
        5'h00: begin
          rd_val = CNAME;
          bad    = ~r_wn;
        end
        5'h01: begin
          rd_val = CVERSION;
          bad    = ~r_wn;
        end
        5'h02: begin
          rd_val[GPIO_W-1:0] = oe_q;
          if (!r_wn) oe_d = wdata[GPIO_W-1:0];
        end
        5'h03: begin
          rd_val[GPIO_W-1:0] = sync2_q;
          if (!r_wn) out_d = wdata[GPIO_W-1:0];
        end
`ifdef GPIO_REGBANK_IRQ_EN
        5'h04: begin
          rd_val[GPIO_W-1:0] = mask_q;
          if (!r_wn) mask_d = wdata[GPIO_W-1:0];
        end
        5'h06: begin
          rd_val[GPIO_W-1:0] = status_q;
          if (!r_wn) w1c = wdata[GPIO_W-1:0];
        end
        5'h07: begin
          rd_val[GPIO_W-1:0] = edge_q;
          if (!r_wn) edge_d = wdata[GPIO_W-1:0];
        end
`endif
        5'h05: begin
          rd_val = scratch_q;
          if (!r_wn) scratch_d = wdata;
        end
        default: bad = 1'b1;
      endcase
      err_d = bad;
      if (r_wn) rdata_d = rd_val;
    end

`ifdef GPIO_REGBANK_IRQ_EN
    // New edges are OR'd in after the clear so a coincident edge keeps the bit set.
    det      = (edge_q & sync2_q & ~prev_q) | (~edge_q & ~sync2_q & prev_q);
    status_d = (status_q & ~w1c) | det;
    irq_d    = |(status_q & mask_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      oe_q      <= '0;
      out_q     <= '0;
      scratch_q <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
`ifdef GPIO_REGBANK_IRQ_EN
      prev_q    <= '0;
      mask_q    <= '0;
      status_q  <= '0;
      edge_q    <= '0;
      irq_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      oe_q      <= oe_d;
      out_q     <= out_d;
      scratch_q <= scratch_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
`ifdef GPIO_REGBANK_IRQ_EN
      prev_q    <= prev_d;
      mask_q    <= mask_d;
      status_q  <= status_d;
      edge_q    <= edge_d;
      irq_q     <= irq_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign gpio_oe  = oe_q;
  assign gpio_out = out_q;
`ifdef GPIO_REGBANK_IRQ_EN
  assign irq      = irq_q;
`else
  assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_regbank.sv
// Self-checking bench for gpio_regbank: table-driven bus vectors plus hand-written
// sequences for interrupts, back-to-back requests and mid-transaction reset.
module tb_gpio_regbank;
  localparam int          W  = 16;
  localparam logic [31:0] CN = 32'h4844_524C;
  localparam logic [31:0] CV = 32'h0102_0304;

  logic          clk = 1'b0;
  logic          reset, req, r_wn;
  logic [4:0]    addr;
  logic [31:0]   wdata, rdata;
  logic          ack, err, irq;
  logic [W-1:0]  gpio_in, gpio_out, gpio_oe;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  gpio_regbank #(.GPIO_W(W), .CNAME(CN), .CVERSION(CV)) dut (
    .clk(clk), .reset(reset), .req(req), .r_wn(r_wn), .addr(addr),
    .wdata(wdata), .ack(ack), .err(err), .rdata(rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the FSM back in IDLE.
  task automatic apply_stimulus(input logic rw, input logic [4:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    req = 1'b1; r_wn = rw; addr = a; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check_output("ack_pulse", 32'(ack), 32'd1);
    rd = rdata;
    er = err;
    @(negedge clk);
    check_output("ack_single", 32'(ack), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          acks;

    vecs[0]  = '{1'b1, 5'h00, 32'h0,         CN,            1'b0};
    vecs[1]  = '{1'b1, 5'h01, 32'h0,         CV,            1'b0};
    vecs[2]  = '{1'b0, 5'h02, 32'hFFFF_00FF, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 5'h03, 32'h0000_A5A5, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 5'h02, 32'h0,         32'h0000_00FF, 1'b0};
    vecs[5]  = '{1'b1, 5'h03, 32'h0,         32'h0000_1234, 1'b0};
    vecs[6]  = '{1'b0, 5'h05, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[7]  = '{1'b1, 5'h05, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{1'b0, 5'h00, 32'h1234_5678, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 5'h00, 32'h0,         CN,            1'b0};
    vecs[10] = '{1'b1, 5'h1F, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{1'b0, 5'h10, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[12] = '{1'b1, 5'h08, 32'h0,         32'h0,         1'b1};

    reset = 1'b1; req = 1'b0; r_wn = 1'b1; addr = '0; wdata = '0; gpio_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_output("reset_ack",   32'(ack),      32'd0);
    check_output("reset_err",   32'(err),      32'd0);
    check_output("reset_rdata", rdata,         32'd0);
    check_output("reset_oe",    32'(gpio_oe),  32'd0);
    check_output("reset_out",   32'(gpio_out), 32'd0);
    check_output("reset_irq",   32'(irq),      32'd0);

    gpio_in = 16'h1234;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].rw, vecs[i].a, vecs[i].wd, rd, er);
      check_output($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      if (vecs[i].rw) check_output($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end
    check_output("gpio_oe",  32'(gpio_oe),  32'h0000_00FF);
    check_output("gpio_out", 32'(gpio_out), 32'h0000_A5A5);

    // Write effect is visible right after the accepting edge.
    req = 1'b1; r_wn = 1'b0; addr = 5'h02; wdata = 32'h0000_0F0F;
    @(posedge clk);
    #1 req = 1'b0;
    check_output("oe_from_edge", 32'(gpio_oe), 32'h0000_0F0F);
    repeat (2) @(negedge clk);

`ifdef GPIO_REGBANK_IRQ_EN
    begin
      int n;
      apply_stimulus(1'b0, 5'h07, 32'h0001, rd, er);
      apply_stimulus(1'b0, 5'h04, 32'h0001, rd, er);
      apply_stimulus(1'b1, 5'h06, 32'h0, rd, er);
      check_output("status_idle", rd, 32'h0);
      check_output("irq_idle", 32'(irq), 32'd0);

      gpio_in[0] = 1'b1;
      n = 0;
      while (!irq && n < 6) begin
        @(negedge clk);
        n++;
      end
      check_output("irq_latency", 32'(irq && n <= 4), 32'd1);
      check_output("irq_not_early", 32'(n >= 4), 32'd1);
      apply_stimulus(1'b1, 5'h06, 32'h0, rd, er);
      check_output("status_set", rd, 32'h0000_0001);

      apply_stimulus(1'b0, 5'h06, 32'h0001, rd, er);
      check_output("irq_after_w1c", 32'(irq), 32'd0);

      gpio_in[0] = 1'b0;
      repeat (5) @(negedge clk);
      check_output("no_fall_set", 32'(irq), 32'd0);

      // Rising edge reaches the compare stage on the same edge as the W1C write.
      gpio_in[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      apply_stimulus(1'b0, 5'h06, 32'h0001, rd, er);
      check_output("irq_set_wins", 32'(irq), 32'd1);
      apply_stimulus(1'b1, 5'h06, 32'h0, rd, er);
      check_output("status_set_wins", rd, 32'h0000_0001);

      apply_stimulus(1'b0, 5'h04, 32'h0000, rd, er);
      @(negedge clk);
      check_output("irq_masked", 32'(irq), 32'd0);
    end
`else
    apply_stimulus(1'b1, 5'h04, 32'h0, rd, er);
    check_output("mask_unmapped_err", 32'(er), 32'd1);
    check_output("mask_unmapped_rd", rd, 32'd0);
    apply_stimulus(1'b1, 5'h06, 32'h0, rd, er);
    check_output("status_unmapped_err", 32'(er), 32'd1);
    gpio_in[0] = 1'b1;
    repeat (6) @(negedge clk);
    check_output("irq_tied_low", 32'(irq), 32'd0);
`endif

    // Six cycles of held req give one transaction every other cycle.
    acks = 0;
    req = 1'b1; r_wn = 1'b1; addr = 5'h05;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    req = 1'b0;
    check_output("b2b_ack_count", 32'(acks), 32'd3);
    @(negedge clk);

    // Reset arriving while in RESP.
    req = 1'b1; r_wn = 1'b1; addr = 5'h00;
    @(posedge clk);
    #1 req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("rst_mid_ack",   32'(ack),      32'd0);
    check_output("rst_mid_rdata", rdata,         32'd0);
    check_output("rst_mid_oe",    32'(gpio_oe),  32'd0);
    check_output("rst_mid_out",   32'(gpio_out), 32'd0);
    check_output("rst_mid_irq",   32'(irq),      32'd0);
    reset = 1'b0;
    @(negedge clk);
    apply_stimulus(1'b1, 5'h05, 32'h0, rd, er);
    check_output("scratch_reset", rd, 32'd0);
    apply_stimulus(1'b1, 5'h01, 32'h0, rd, er);
    check_output("post_reset_cver", rd, CV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
